// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared opcode, state and width definitions for calc_seq_alu
package calc_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD    = 3'd0,
        OP_SUB_AB = 3'd1,
        OP_SUB_BA = 3'd2,
        OP_ABS_A  = 3'd3,
        OP_ABS_B  = 3'd4,
        OP_MUL    = 3'd5
    } calc_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_FIX  = 2'd3
    } calc_state_e;

endpackage

// File: rtl/calc_seq_alu_if.sv
// rtl/calc_seq_alu_if.sv - start/busy/done request and result bundle for calc_seq_alu
interface calc_seq_alu_if
    import calc_pkg::*;
#(
    parameter int W = 4
);
    logic              start;
    logic [OP_W-1:0]   op;
    logic [W-1:0]      a;
    logic [W-1:0]      b;
    logic              busy;
    logic              done;
    logic [2*W-1:0]    result;
    logic              ovf;
    logic              err;

    modport master (output start, op, a, b, input busy, done, result, ovf, err);
    modport slave  (input start, op, a, b, output busy, done, result, ovf, err);
endinterface

// File: rtl/calc_mul_seq.sv
// rtl/calc_mul_seq.sv - unsigned shift-add multiplier core, one multiplier bit per step
module calc_mul_seq #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [W-1:0]   mcand,
    input  logic [W-1:0]   mplier,
    output logic [2*W-1:0] product
);
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] mcand_q, mcand_d;
    logic [W-1:0]   mplier_q, mplier_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load) begin
            acc_d    = '0;
            mcand_d  = {{W{1'b0}}, mcand};
            mplier_d = mplier;
        end else if (step) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    assign product = acc_q;
endmodule

// File: rtl/calc_seq_alu.sv
// rtl/calc_seq_alu.sv - registered signed add/sub/abs calculator; CALC_SEQ_ALU_MUL_EN adds iterative multiply
module calc_seq_alu
    import calc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          rst,
    calc_seq_alu_if.slave bus
);
    localparam int RW = 2 * W;

    calc_state_e       state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d;
    logic [RW-1:0]     result_q, result_d;
    logic              ovf_q, ovf_d, err_q, err_d, done_q, done_d;

    logic signed [RW-1:0] a_x, b_x, alu_res;
    logic                 alu_err, alu_ovf;
    logic [W:0]           alu_top;

    assign a_x = {{W{a_q[W-1]}}, a_q};
    assign b_x = {{W{b_q[W-1]}}, b_q};

    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            OP_ADD:    alu_res = a_x + b_x;
            OP_SUB_AB: alu_res = a_x - b_x;
            OP_SUB_BA: alu_res = b_x - a_x;
            OP_ABS_A:  alu_res = a_q[W-1] ? -a_x : a_x;
            OP_ABS_B:  alu_res = b_q[W-1] ? -b_x : b_x;
            default:   alu_err = 1'b1;
        endcase
    end

    // Fits W-bit signed exactly when the top W+1 bits are a pure sign extension.
    assign alu_top = alu_res[RW-1:W-1];
    assign alu_ovf = !((&alu_top) || !(|alu_top));

`ifdef CALC_SEQ_ALU_MUL_EN
    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          mul_load, mul_step, mul_neg, mul_ovf;
    logic [W-1:0]  mag_a, mag_b;
    logic [RW-1:0] mul_prod, mul_res;
    logic [W:0]    mul_top;

    assign mag_a   = bus.a[W-1] ? (~bus.a + W'(1)) : bus.a;
    assign mag_b   = bus.b[W-1] ? (~bus.b + W'(1)) : bus.b;
    assign mul_neg = a_q[W-1] ^ b_q[W-1];
    assign mul_res = mul_neg ? (~mul_prod + RW'(1)) : mul_prod;
    assign mul_top = mul_res[RW-1:W-1];
    assign mul_ovf = !((&mul_top) || !(|mul_top));

    calc_mul_seq #(.W(W)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .load    (mul_load),
        .step    (mul_step),
        .mcand   (mag_a),
        .mplier  (mag_b),
        .product (mul_prod)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        done_d   = 1'b0;
`ifdef CALC_SEQ_ALU_MUL_EN
        cnt_d    = cnt_q;
        mul_load = 1'b0;
        mul_step = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    state_d = ST_EXEC;
`ifdef CALC_SEQ_ALU_MUL_EN
                    if (bus.op == OP_MUL) begin
                        state_d  = ST_MUL;
                        mul_load = 1'b1;
                        cnt_d    = '0;
                    end
`endif
                end
            end
            ST_EXEC: begin
                result_d = alu_res;
                ovf_d    = alu_ovf;
                err_d    = alu_err;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
`ifdef CALC_SEQ_ALU_MUL_EN
            ST_MUL: begin
                mul_step = 1'b1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = mul_res;
                ovf_d    = mul_ovf;
                err_d    = 1'b0;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.ovf    = ovf_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_calc_seq_alu.sv
// tb/tb_calc_seq_alu.sv - randomized and directed checks of calc_seq_alu against a behavioural model
module tb_calc_seq_alu;
    localparam int W = 4;
`ifdef CALC_SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    calc_seq_alu_if #(.W(W)) bus ();

    calc_seq_alu #(.W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted request completes a fixed number of edges later.
    int m_left = 0;
    bit m_done = 0, m_ovf = 0, m_err = 0;
    int m_res = 0;
    bit p_ovf, p_err;
    int p_res;

    always @(posedge clk or posedge rst) begin : model
        int sa, sb, r, lat;
        bit e;
        if (rst) begin
            m_left = 0; m_done = 0; m_res = 0; m_ovf = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1; m_res = p_res; m_ovf = p_ovf; m_err = p_err;
                end
            end else if (bus.start) begin
                sa = $signed(bus.a);
                sb = $signed(bus.b);
                r = 0; e = 0; lat = 1;
                case (bus.op)
                    3'd0: r = sa + sb;
                    3'd1: r = sa - sb;
                    3'd2: r = sb - sa;
                    3'd3: r = (sa < 0) ? -sa : sa;
                    3'd4: r = (sb < 0) ? -sb : sb;
                    3'd5: if (MUL_EN) begin r = sa * sb; lat = W + 1; end else e = 1;
                    default: e = 1;
                endcase
                p_res = r;
                p_err = e;
                p_ovf = (r < -(1 << (W - 1))) || (r > (1 << (W - 1)) - 1);
                m_left = lat;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [2*W-1:0] er;
        er = m_res[2*W-1:0];
        chk("busy",   bus.busy, m_left > 0);
        chk("done",   bus.done, m_done);
        chk("result", longint'(bus.result), longint'(er));
        chk("ovf",    bus.ovf, m_ovf);
        chk("err",    bus.err, m_err);
    end

    task automatic wait_done(output int lat);
        lat = 0;
        while (!bus.done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input int av, input int bv,
                          input logic [2*W-1:0] er, input bit eo, input bit ee, input int el);
        int lat;
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = av[W-1:0];
        bus.b     = bv[W-1:0];
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        wait_done(lat);
        chk({nm, "_lat"},    lat, el);
        chk({nm, "_result"}, longint'(bus.result), longint'(er));
        chk({nm, "_ovf"},    bus.ovf, eo);
        chk({nm, "_err"},    bus.err, ee);
    endtask

    initial begin
        int lat;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_result", longint'(bus.result), 0);
        chk("rst_err", bus.err, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op("add_7_1",    3'd0, 7, 1, 8'h08, 1'b1, 1'b0, 1);
        run_op("subba_3_m5", 3'd2, 3, -5, 8'hF8, 1'b0, 1'b0, 1);
        run_op("absa_m8",    3'd3, -8, 2, 8'h08, 1'b1, 1'b0, 1);
        run_op("mul_m8_m8",  3'd5, -8, -8, MUL_EN ? 8'h40 : 8'h00, MUL_EN, !MUL_EN, MUL_EN ? 5 : 1);
        run_op("add_clr",    3'd0, -2, 1, 8'hFF, 1'b0, 1'b0, 1);
        run_op("mul_m3_5",   3'd5, -3, 5, MUL_EN ? 8'hF1 : 8'h00, MUL_EN, !MUL_EN, MUL_EN ? 5 : 1);
        run_op("ill_110",    3'd6, 1, 2, 8'h00, 1'b0, 1'b1, 1);
        run_op("sub_clr",    3'd1, 1, 3, 8'hFE, 1'b0, 1'b0, 1);

        // Start held high with new operands while busy, still high on the done cycle.
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 4'd2; bus.b = 4'd3;
        @(negedge clk);
        bus.op = 3'd0; bus.a = 4'd5; bus.b = 4'hE;
        wait_done(lat);
        chk("hold_lat", lat, MUL_EN ? 5 : 1);
        chk("hold_result", longint'(bus.result), MUL_EN ? 6 : 0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(lat);
        chk("ondone_lat", lat, 1);
        chk("ondone_result", longint'(bus.result), 3);
        chk("ondone_err", bus.err, 0);

        // Asynchronous reset between edges while an operation is in flight.
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 4'hD; bus.b = 4'd5;
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_result", longint'(bus.result), 0);
        chk("arst_ovf", bus.ovf, 0);
        chk("arst_err", bus.err, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("add_after_rst", 3'd0, 2, 3, 8'h05, 1'b0, 1'b0, 1);

        for (int i = 0; i < 600; i++) begin
            bus.start = ($urandom_range(0, 2) == 0);
            bus.op    = 3'($urandom_range(0, 7));
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            @(negedge clk);
        end
        bus.start = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
